// File: rtl/alu_unit_pkg.sv
// Shared configuration: opcode encodings and field widths used by
// the decoder, reservation station and ALU. Optional feature macro: ALU_MUL_EN.
package alu_unit_pkg;

    localparam int RS_TYPE_BIT  = 5;
    localparam int ROB_SIZE_BIT = 4;

    typedef enum logic [RS_TYPE_BIT-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_EQ     = 5'd10,
        OP_NE     = 5'd11,
        OP_LT     = 5'd12,
        OP_GE     = 5'd13,
        OP_LTU    = 5'd14,
        OP_GEU    = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19
    } alu_op_e;

    function automatic logic [31:0] flag32(input logic b);
        return {31'd0, b};
    endfunction

endpackage

// File: rtl/alu_unit_core.sv
// Combinational ALU datapath: opcode + operands -> 32-bit result.
// Multiply opcodes only decode when ALU_MUL_EN is defined.
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [RS_TYPE_BIT-1:0] op_i,
    input  logic [31:0]            a_i,
    input  logic [31:0]            b_i,
    output logic [31:0]            res_o
);

    alu_op_e     op;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;

    assign op    = alu_op_e'(op_i);
    assign shamt = b_i[4:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

`ifdef ALU_MUL_EN
    logic [63:0] p_ss;
    logic [63:0] p_su;
    logic [63:0] p_uu;

    // Low 64 bits of the extended products give every RV32M variant.
    assign p_ss = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign p_su = {{32{a_i[31]}}, a_i} * {32'd0, b_i};
    assign p_uu = {32'd0, a_i} * {32'd0, b_i};
`endif

    // Result select; unknown opcodes yield zero.
    always_comb begin
        res_o = 32'd0;
        case (op)
            OP_ADD:    res_o = a_i + b_i;
            OP_SUB:    res_o = a_i - b_i;
            OP_AND:    res_o = a_i & b_i;
            OP_OR:     res_o = a_i | b_i;
            OP_XOR:    res_o = a_i ^ b_i;
            OP_SLL:    res_o = a_i << shamt;
            OP_SRL:    res_o = a_i >> shamt;
            OP_SRA:    res_o = $unsigned($signed(a_i) >>> shamt);
            OP_SLT:    res_o = flag32(lt_s);
            OP_SLTU:   res_o = flag32(lt_u);
            OP_EQ:     res_o = flag32(a_i == b_i);
            OP_NE:     res_o = flag32(a_i != b_i);
            OP_LT:     res_o = flag32(lt_s);
            OP_GE:     res_o = flag32(!lt_s);
            OP_LTU:    res_o = flag32(lt_u);
            OP_GEU:    res_o = flag32(!lt_u);
`ifdef ALU_MUL_EN
            OP_MUL:    res_o = p_ss[31:0];
            OP_MULH:   res_o = p_ss[63:32];
            OP_MULHSU: res_o = p_su[63:32];
            OP_MULHU:  res_o = p_uu[63:32];
`endif
            default:   res_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle ALU execution unit: result register, flush and counter.
// Optional multiply support via macro ALU_MUL_EN (see alu_core).
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    alu_input,
    input  logic [RS_TYPE_BIT-1:0]  arith_type,
    input  logic [31:0]             alu_r1_val,
    input  logic [31:0]             alu_r2_val,
    input  logic [ROB_SIZE_BIT-1:0] inst_rob_id,
    output logic                    alu_fi,
    output logic [31:0]             alu_value,
    output logic [ROB_SIZE_BIT-1:0] alu_rob_id,
    output logic [31:0]             alu_op_cnt
);

    logic                    fi_q,  fi_d;
    logic [31:0]             val_q, val_d;
    logic [ROB_SIZE_BIT-1:0] tag_q, tag_d;
    logic [31:0]             cnt_q, cnt_d;

    alu_core u_core (
        .op_i  (arith_type),
        .a_i   (alu_r1_val),
        .b_i   (alu_r2_val),
        .res_o (val_d)
    );

    // Next-state: a flush kills the issue in the same cycle.
    always_comb begin
        fi_d  = alu_input & ~rob_clear;
        tag_d = inst_rob_id;
        cnt_d = cnt_q + {31'd0, fi_d};
    end

    // Result register; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fi_q  <= 1'b0;
            val_q <= 32'd0;
            tag_q <= '0;
            cnt_q <= 32'd0;
        end else if (rdy_in) begin
            fi_q  <= fi_d;
            val_q <= val_d;
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

    assign alu_fi     = fi_q;
    assign alu_value  = val_q;
    assign alu_rob_id = tag_q;
    assign alu_op_cnt = cnt_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table plus
// hand-written stall, flush and reset sequences.
module tb_alu_unit;
    import alu_unit_pkg::*;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    rdy_in;
    logic                    rob_clear;
    logic                    alu_input;
    logic [RS_TYPE_BIT-1:0]  arith_type;
    logic [31:0]             alu_r1_val;
    logic [31:0]             alu_r2_val;
    logic [ROB_SIZE_BIT-1:0] inst_rob_id;
    logic                    alu_fi;
    logic [31:0]             alu_value;
    logic [ROB_SIZE_BIT-1:0] alu_rob_id;
    logic [31:0]             alu_op_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    alu_unit dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear   (rob_clear),
        .alu_input   (alu_input),
        .arith_type  (arith_type),
        .alu_r1_val  (alu_r1_val),
        .alu_r2_val  (alu_r2_val),
        .inst_rob_id (inst_rob_id),
        .alu_fi      (alu_fi),
        .alu_value   (alu_value),
        .alu_rob_id  (alu_rob_id),
        .alu_op_cnt  (alu_op_cnt)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

`ifdef ALU_MUL_EN
    localparam logic [31:0] MULHU_EXP = 32'hFFFF_FFFE;
    localparam logic [31:0] MUL_EXP   = 32'd21;
`else
    localparam logic [31:0] MULHU_EXP = 32'h0;
    localparam logic [31:0] MUL_EXP   = 32'h0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        alu_input   = v;
        arith_type  = op;
        alu_r1_val  = a;
        alu_r2_val  = b;
        inst_rob_id = tag;
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    logic [31:0] cnt_exp;

    initial begin
        vecs[0]  = '{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{5'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[2]  = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3]  = '{5'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        vecs[4]  = '{5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[5]  = '{5'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        vecs[6]  = '{5'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
        vecs[7]  = '{5'd6,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        vecs[8]  = '{5'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[9]  = '{5'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{5'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001};
        vecs[11] = '{5'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        vecs[12] = '{5'd12, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[13] = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[14] = '{5'd14, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[15] = '{5'd15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[16] = '{5'd31, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000};
        vecs[17] = '{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU_EXP};
        vecs[18] = '{5'd16, 32'h0000_0003, 32'h0000_0007, MUL_EXP};

        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        rob_clear = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        #2;
        chk("reset_fi",  {31'd0, alu_fi}, 32'd0);
        chk("reset_val", alu_value, 32'd0);
        chk("reset_tag", {28'd0, alu_rob_id}, 32'd0);
        chk("reset_cnt", alu_op_cnt, 32'd0);
        step;
        step;
        rst_in = 1'b1;
        step;
        chk("idle_after_reset", {31'd0, alu_fi}, 32'd0);

        cnt_exp = 32'd0;
        for (int i = 0; i < NV; i++) begin
            logic [3:0] tag;
            tag = (i == 0) ? 4'd3 : 4'(i);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, tag);
            step;
            cnt_exp++;
            chk($sformatf("v%0d_fi", i), {31'd0, alu_fi}, 32'd1);
            chk($sformatf("v%0d_val", i), alu_value, vecs[i].exp);
            chk($sformatf("v%0d_tag", i), {28'd0, alu_rob_id}, {28'd0, tag});
            chk($sformatf("v%0d_cnt", i), alu_op_cnt, cnt_exp);
        end

        drive(1'b0, 5'd0, 32'd1, 32'd1, 4'd0);
        step;
        chk("idle_fi",  {31'd0, alu_fi}, 32'd0);
        chk("idle_cnt", alu_op_cnt, cnt_exp);

        drive(1'b1, 5'd0, 32'd1, 32'd2, 4'd5);
        rob_clear = 1'b1;
        step;
        rob_clear = 1'b0;
        chk("flush_fi",  {31'd0, alu_fi}, 32'd0);
        chk("flush_cnt", alu_op_cnt, cnt_exp);

        drive(1'b1, 5'd0, 32'd10, 32'd1, 4'd1);
        step;
        chk("stall_t1_tag", {28'd0, alu_rob_id}, 32'd1);
        chk("stall_t1_val", alu_value, 32'd11);
        chk("stall_t1_cnt", alu_op_cnt, cnt_exp + 1);
        drive(1'b1, 5'd0, 32'd20, 32'd2, 4'd2);
        rdy_in = 1'b0;
        step;
        chk("stall_hold_fi",  {31'd0, alu_fi}, 32'd1);
        chk("stall_hold_tag", {28'd0, alu_rob_id}, 32'd1);
        chk("stall_hold_val", alu_value, 32'd11);
        chk("stall_hold_cnt", alu_op_cnt, cnt_exp + 1);
        rdy_in = 1'b1;
        step;
        chk("stall_t2_fi",  {31'd0, alu_fi}, 32'd1);
        chk("stall_t2_tag", {28'd0, alu_rob_id}, 32'd2);
        chk("stall_t2_val", alu_value, 32'd22);
        drive(1'b1, 5'd1, 32'd30, 32'd3, 4'd3);
        step;
        chk("stall_t3_fi",  {31'd0, alu_fi}, 32'd1);
        chk("stall_t3_tag", {28'd0, alu_rob_id}, 32'd3);
        chk("stall_t3_val", alu_value, 32'd27);
        chk("stall_cnt", alu_op_cnt, cnt_exp + 3);
        cnt_exp = cnt_exp + 3;

        drive(1'b1, 5'd2, 32'hFFFF_0000, 32'h00FF_FF00, 4'd9);
        step;
        chk("pre_rst_fi", {31'd0, alu_fi}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_fi",  {31'd0, alu_fi}, 32'd0);
        chk("async_rst_val", alu_value, 32'd0);
        chk("async_rst_tag", {28'd0, alu_rob_id}, 32'd0);
        chk("async_rst_cnt", alu_op_cnt, 32'd0);
        #3;
        rst_in = 1'b1;
        step;
        chk("post_rst_idle", {31'd0, alu_fi}, 32'd0);
        drive(1'b1, 5'd4, 32'h0000_00FF, 32'h0000_000F, 4'd7);
        step;
        chk("post_rst_val", alu_value, 32'h0000_00F0);
        chk("post_rst_tag", {28'd0, alu_rob_id}, 32'd7);
        chk("post_rst_cnt", alu_op_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
